// File: rtl/fp_sub_seq.sv
// Multi-cycle binary32 subtractor, result = data1 - data2.
// Truncating datapath: one-bit-per-cycle alignment and normalisation.
module fp_sub_seq #(
   parameter int MAX_ALIGN = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);

   typedef enum logic [2:0] {
      IDLE, SWAP, SHIFT, ADDSUB, NORM, DONE
   } state_t;

   localparam logic [7:0] MAX_A = 8'(MAX_ALIGN);

   state_t      state, state_nx;
   logic        sa, sb, sign;
   logic [7:0]  ea, eb, exp, cnt;
   logic [23:0] ma, mb;
   logic [24:0] sum;

   logic        accept, in_spec;
   logic        a_inf, b_inf, a_nan, b_nan;
   logic [31:0] spec_res;
   logic        swap_do;
   logic [7:0]  diff, cnt_sw;
   logic [7:0]  exp_inc;
   logic        norm_end;

   assign accept  = in_valid && in_ready;
   assign a_inf   = (data1[30:23] == 8'hFF) && (data1[22:0] == '0);
   assign b_inf   = (data2[30:23] == 8'hFF) && (data2[22:0] == '0);
   assign a_nan   = (data1[30:23] == 8'hFF) && (data1[22:0] != '0);
   assign b_nan   = (data2[30:23] == 8'hFF) && (data2[22:0] != '0);
   assign in_spec = (data1[30:23] == 8'hFF) || (data2[30:23] == 8'hFF);

   // Subtrahend sign is inverted, so inf - inf shows up as equal signs
   always_comb begin
      spec_res = {~data2[31], 8'hFF, 23'd0};
      if (a_nan || b_nan || (a_inf && b_inf && (data1[31] == data2[31])))
         spec_res = 32'h7FC0_0000;
      else if (a_inf)
         spec_res = {data1[31], 8'hFF, 23'd0};
   end

   assign swap_do = (eb > ea) || ((eb == ea) && (mb > ma));
   assign diff    = swap_do ? (eb - ea) : (ea - eb);
   assign cnt_sw  = (diff > MAX_A) ? MAX_A : diff;
   assign exp_inc = exp + 8'd1;
   assign norm_end = (sum == '0) || sum[24] || sum[23] || (exp == 8'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = in_spec ? DONE : SWAP;
         SWAP:    state_nx = (cnt_sw != '0) ? SHIFT : ADDSUB;
         SHIFT:   if (cnt == 8'd1) state_nx = ADDSUB;
         ADDSUB:  state_nx = NORM;
         NORM:    if (norm_end) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa <= 1'b0; sb <= 1'b0; sign <= 1'b0;
         ea <= '0; eb <= '0; exp <= '0; cnt <= '0;
         ma <= '0; mb <= '0; sum <= '0;
         result <= '0; overflow <= 1'b0; underflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               overflow  <= 1'b0;
               underflow <= 1'b0;
               if (in_spec) begin
                  result <= spec_res;
               end else begin
                  sa <= data1[31];
                  sb <= ~data2[31];
                  ea <= data1[30:23];
                  eb <= data2[30:23];
                  ma <= (data1[30:23] == '0) ? '0 : {1'b1, data1[22:0]};
                  mb <= (data2[30:23] == '0) ? '0 : {1'b1, data2[22:0]};
               end
            end
            SWAP: begin
               if (swap_do) begin
                  sa <= sb; sb <= sa;
                  ea <= eb; eb <= ea;
                  ma <= mb; mb <= ma;
                  mb <= ma >> 0;
               end
               cnt <= cnt_sw;
            end
            SHIFT: begin
               mb  <= mb >> 1;
               cnt <= cnt - 8'd1;
            end
            ADDSUB: begin
               sum  <= (sa == sb) ? ({1'b0, ma} + {1'b0, mb})
                                  : ({1'b0, ma} - {1'b0, mb});
               exp  <= ea;
               sign <= sa;
            end
            NORM: begin
               if (sum == '0) begin
                  result <= '0;
               end else if (sum[24]) begin
                  sum <= sum >> 1;
                  exp <= exp_inc;
                  if (exp_inc == 8'hFF) begin
                     result   <= {sign, 8'hFF, 23'd0};
                     overflow <= 1'b1;
                  end else begin
                     result <= {sign, exp_inc, sum[23:1]};
                  end
               end else if (sum[23]) begin
                  result <= {sign, exp, sum[22:0]};
               end else if (exp == 8'd1) begin
                  result    <= {sign, 31'd0};
                  underflow <= 1'b1;
               end else begin
                  sum <= sum << 1;
                  exp <= exp - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed-vector bench for fp_sub_seq.
// Checks results, flags, latency, back-pressure and mid-op reset.
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   fp_sub_seq #(.MAX_ALIGN(25)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data1     (data1),
      .data2     (data2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Issue one operation; latency counts the accept edge as cycle 1
   task automatic run_op(input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res,
                         input logic exp_ov, input logic exp_uf,
                         input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      data1    = a;
      data2    = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_ov"}, 32'(overflow), 32'(exp_ov));
      chk({tag, "_uf"}, 32'(underflow), 32'(exp_uf));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_hold_res"}, result, exp_res);
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_retire_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_retire_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data1     = '0;
      data2     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("three_m_one", 32'h4040_0000, 32'h3F80_0000,
             32'h4000_0000, 1'b0, 1'b0, 5, 0);
      run_op("one_m_one", 32'h3F80_0000, 32'h3F80_0000,
             32'h0000_0000, 1'b0, 1'b0, 4, 0);
      run_op("carry", 32'h3F80_0000, 32'hBF80_0000,
             32'h4000_0000, 1'b0, 1'b0, 4, 0);
      run_op("ovf", 32'h7F7F_FFFF, 32'hFF7F_FFFF,
             32'h7F80_0000, 1'b1, 1'b0, 4, 0);
      run_op("cancel", 32'h3F80_0000, 32'h3F80_0001,
             32'hB400_0000, 1'b0, 1'b0, 27, 0);
      run_op("unf", 32'h0080_0001, 32'h0080_0000,
             32'h0000_0000, 1'b0, 1'b1, 4, 0);
      run_op("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000,
             32'h7FC0_0000, 1'b0, 1'b0, 1, 0);
      run_op("one_m_inf", 32'h3F80_0000, 32'h7F80_0000,
             32'hFF80_0000, 1'b0, 1'b0, 1, 0);
      run_op("hold", 32'h4040_0000, 32'h3F80_0000,
             32'h4000_0000, 1'b0, 1'b0, 5, 3);

      // 2^23 - 1.0 needs 23 alignment shifts; reset lands inside SHIFT
      @(negedge clk);
      data1    = 32'h4B00_0000;
      data2    = 32'h3F80_0000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("after_rst", 32'h4040_0000, 32'h3F80_0000,
             32'h4000_0000, 1'b0, 1'b0, 5, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
